fixed_encoder_multi_order: RTL and testbench
============================================

FIXED_ENCODER_MULTI_ORDER -- requirements
Module: fixed_encoder_multi_order

Interface
REQ-001 Parameter SAMPLE_W, default 16: signed input sample width (8..32).
REQ-002 Parameter MAX_ORDER, default 4: highest fixed-predictor order built (1..4).
REQ-003 Parameter ACC_W, default 32: width of the abs-residual accumulator (FIXED_ENC_ABSSUM_EN only).
REQ-004 Port iClock input 1: the single clock; all state changes on its rising edge.
REQ-005 Port iReset_n input 1: asynchronous, active-low reset.
REQ-006 Port iValid input 1: iSample, iFrameStart and iOrder are valid this cycle.
REQ-007 Port iSample input SAMPLE_W: signed PCM sample.
REQ-008 Port iFrameStart input 1: qualifies the current valid sample as the first sample of a frame.
REQ-009 Port iOrder input 3: requested predictor order, sampled only with iFrameStart && iValid.
REQ-010 Port oValid output 1: oResidual and oWarmup are valid.
REQ-011 Port oResidual output SAMPLE_W+4: signed residual, or sign-extended verbatim sample during warmup.
REQ-012 Port oWarmup output 1: oResidual is a verbatim warmup sample.
REQ-013 Port oAbsSum output ACC_W: running frame sum of |residual| (present only with FIXED_ENC_ABSSUM_EN).

Function
REQ-014 The block SHALL compute FLAC fixed residuals: order0 x; order1 x-x1; order2 x-2x1+x2; order3 x-3x1+3x2-x3; order4 x-4x1+6x2-4x3+x4, where xk is the k-th previous valid sample of the current frame.
REQ-015 Arithmetic SHALL be exact in SAMPLE_W+4 bits; no saturation or wrap is possible or permitted.
REQ-016 Latency SHALL be exactly 3 cycles for every order: a sample accepted on edge N produces oValid=1 on edge N+3.
REQ-017 Cycles with iValid=0 SHALL NOT advance history, warmup count or pipeline contents; they produce oValid=0 three cycles later.
REQ-018 No backpressure: every accepted sample produces exactly one output, in order.
REQ-019 On iFrameStart && iValid, the block SHALL latch iOrder (values above MAX_ORDER clamped to MAX_ORDER), clear history and reset the warmup count to 0.
REQ-020 iOrder SHALL be ignored when iFrameStart is 0; mid-frame order changes have no effect.
REQ-021 The first latched-order samples of a frame SHALL output oWarmup=1 with oResidual = sign-extended sample; subsequent samples output oWarmup=0 and the residual.
REQ-022 The warmup counter SHALL saturate at the latched order.
REQ-023 Samples received after reset but before any iFrameStart SHALL use order 0 (residual = sample, oWarmup=0).
REQ-024 Consecutive frames with back-to-back iFrameStart SHALL not mix history across the boundary.

Reset
REQ-025 While iReset_n=0: oValid=0, oResidual=0, oWarmup=0, oAbsSum=0, history=0, latched order=0, warmup count=0, all in-flight pipeline entries discarded.
REQ-026 Reset asserted mid-frame SHALL drop all pending outputs; no oValid may appear from pre-reset samples.

Configuration
REQ-027 Macro FIXED_ENC_ABSSUM_EN defined: oAbsSum present; it SHALL update with each oValid to the sum of |oResidual| over non-warmup outputs of the current frame including the present one, clear to 0 (then add) on the output of a frame-start sample, and saturate at 2^ACC_W-1.
REQ-028 Macro undefined: port oAbsSum and its accumulator SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package fixed_enc_pkg SHALL hold the order typedef (3-bit), the coefficient constants per order, LATENCY=3 and the residual-width function SAMPLE_W+4.
REQ-030 Sub-module fixed_enc_history SHALL implement the MAX_ORDER-deep sample delay line with valid-gated shift and synchronous clear on frame start.

Verification
REQ-031 Order 2, frame start, samples 10,20,35,55 -> outputs 10(W),20(W),5,5, each 3 cycles after input.
REQ-032 Order 4, SAMPLE_W=16, samples 32767,-32768,32767,-32768,32767 -> fifth output 524280, oWarmup=0, no overflow.
REQ-033 Order 1, samples 5,_,_,9 with iValid low for two gap cycles -> outputs 5(W),4 with matching two-cycle output gap.
REQ-034 iOrder=7 with MAX_ORDER=3 at frame start -> order 3 used; iOrder change to 0 mid-frame ignored.
REQ-035 Frame A order 1 samples 100,50 then immediate frame B order 1 sample 7 -> 100(W),-50,7(W); no history from frame A.
REQ-036 iReset_n low for 1 cycle with 2 samples in flight -> no oValid for those samples; with FIXED_ENC_ABSSUM_EN, oAbsSum=0 after reset and equals 10 after the REQ-031 sequence.

Source files
------------

// File: rtl/fixed_encoder_multi_order_pkg.sv
// -----------------------------------------------------------------------------
// fixed_enc_pkg
// Shared definitions for the multi-order FLAC fixed-predictor encoder:
//   order_t        3-bit predictor order
//   LATENCY        cycles from an accepted sample to its output
//   resid_w()      residual width for a given sample width (sample + 4 bits)
//   fixed_coef()   coefficient applied to the k-th previous sample per order
//   clamp_order()  limits a requested order to the highest order built
// -----------------------------------------------------------------------------
package fixed_enc_pkg;

    typedef logic [2:0] order_t;

    localparam int LATENCY = 32'sd3;

    // Worst case |residual| is 16 * 2^(W-1), which fits in W+4 signed bits.
    function automatic int resid_w(input int sample_w);
        return sample_w + 32'sd4;
    endfunction

    // Binomial coefficients (with sign) of the k-th previous sample, k = 1..4.
    function automatic int fixed_coef(input order_t ord, input int k);
        int c;
        c = 32'sd0;
        case (ord)
            3'd1: begin
                if (k == 32'sd1) c = -32'sd1;
                else             c = 32'sd0;
            end
            3'd2: begin
                case (k)
                    32'sd1:  c = -32'sd2;
                    32'sd2:  c = 32'sd1;
                    default: c = 32'sd0;
                endcase
            end
            3'd3: begin
                case (k)
                    32'sd1:  c = -32'sd3;
                    32'sd2:  c = 32'sd3;
                    32'sd3:  c = -32'sd1;
                    default: c = 32'sd0;
                endcase
            end
            3'd4: begin
                case (k)
                    32'sd1:  c = -32'sd4;
                    32'sd2:  c = 32'sd6;
                    32'sd3:  c = -32'sd4;
                    32'sd4:  c = 32'sd1;
                    default: c = 32'sd0;
                endcase
            end
            default: c = 32'sd0;
        endcase
        return c;
    endfunction

    function automatic order_t clamp_order(input order_t req, input int max_ord);
        if (int'(req) > max_ord) return order_t'(max_ord);
        else                     return req;
    endfunction

endpackage

// File: rtl/fixed_encoder_multi_order_if.sv
// -----------------------------------------------------------------------------
// fixed_encoder_multi_order_if
// Sample-in / residual-out bundle of the fixed-predictor encoder.
//   iValid, iSample, iFrameStart, iOrder : sample stream into the encoder
//   oValid, oResidual, oWarmup           : residual stream out of the encoder
//   oAbsSum                              : running frame |residual| sum
//                                          (only with FIXED_ENC_ABSSUM_EN)
// master = stream source/sink side, slave = encoder side.
// -----------------------------------------------------------------------------
interface fixed_encoder_multi_order_if #(
    parameter int SAMPLE_W = 16
`ifdef FIXED_ENC_ABSSUM_EN
  , parameter int ACC_W    = 32
`endif
) ();

    logic                          iValid;
    logic signed [SAMPLE_W-1:0]    iSample;
    logic                          iFrameStart;
    fixed_enc_pkg::order_t         iOrder;
    logic                          oValid;
    logic signed [SAMPLE_W+3:0]    oResidual;
    logic                          oWarmup;

`ifdef FIXED_ENC_ABSSUM_EN
    logic        [ACC_W-1:0]       oAbsSum;

    modport master (output iValid, iSample, iFrameStart, iOrder,
                    input  oValid, oResidual, oWarmup, oAbsSum);
    modport slave  (input  iValid, iSample, iFrameStart, iOrder,
                    output oValid, oResidual, oWarmup, oAbsSum);
`else
    modport master (output iValid, iSample, iFrameStart, iOrder,
                    input  oValid, oResidual, oWarmup);
    modport slave  (input  iValid, iSample, iFrameStart, iOrder,
                    output oValid, oResidual, oWarmup);
`endif

endinterface

// File: rtl/fixed_encoder_multi_order_history.sv
// -----------------------------------------------------------------------------
// fixed_enc_history
// MAX_ORDER-deep delay line of previous samples of the current frame.
//   iClock, iReset_n : clock, async active-low reset
//   i_valid          : shift in i_sample this cycle
//   i_clear          : i_sample starts a new frame; older history is dropped
//   i_sample         : sample to store
//   o_hist[k]        : (k+1)-th previous sample; taps beyond MAX_ORDER read 0
// -----------------------------------------------------------------------------
module fixed_enc_history #(
    parameter int SAMPLE_W  = 16,
    parameter int MAX_ORDER = 4
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    input  logic                      i_valid,
    input  logic                      i_clear,
    input  logic [SAMPLE_W-1:0]       i_sample,
    output logic [3:0][SAMPLE_W-1:0]  o_hist
);

    logic [MAX_ORDER-1:0][SAMPLE_W-1:0] r_hist;

    // Shift on every accepted sample; a frame start keeps only the new sample.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_hist <= '0;
        end else if (i_valid) begin
            if (i_clear) begin
                r_hist    <= '0;
                r_hist[0] <= i_sample;
            end else begin
                r_hist[0] <= i_sample;
                for (int i = 1; i < MAX_ORDER; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_tap
        if (k < MAX_ORDER) begin : g_live
            assign o_hist[k] = r_hist[k];
        end else begin : g_zero
            assign o_hist[k] = '0;
        end
    end

endmodule

// File: rtl/fixed_encoder_multi_order.sv
// -----------------------------------------------------------------------------
// fixed_encoder_multi_order
// FLAC fixed-predictor (orders 0..MAX_ORDER) residual encoder, 3-cycle latency.
//   iClock, iReset_n : clock, async active-low reset
//   bus (slave)      : sample stream in, residual/warmup stream out
// Optional macro FIXED_ENC_ABSSUM_EN adds bus.oAbsSum, the saturating sum of
// |residual| over the non-warmup outputs of the current frame.
// Pipeline: edge N capture, N+1 residual, N+2 magnitude, N+3 output registers.
// -----------------------------------------------------------------------------
module fixed_encoder_multi_order
    import fixed_enc_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int MAX_ORDER = 4,
    parameter int ACC_W     = 32
) (
    input  logic                        iClock,
    input  logic                        iReset_n,
    fixed_encoder_multi_order_if.slave  bus
);

    localparam int RW = resid_w(SAMPLE_W);

    if (SAMPLE_W < 32'sd8 || SAMPLE_W > 32'sd32) begin : g_bad_sample_w
        $error("SAMPLE_W must be 8..32");
    end
    if (MAX_ORDER < 32'sd1 || MAX_ORDER > 32'sd4) begin : g_bad_max_order
        $error("MAX_ORDER must be 1..4");
    end
    if (ACC_W < RW) begin : g_bad_acc_w
        $error("ACC_W must hold at least one residual magnitude");
    end

    // Frame state and front-end decode
    order_t                      r_order, r_warm_cnt;
    order_t                      w_ord_s, w_cnt_base_s;
    logic                        w_start_s, w_warm_s;
    logic [3:0][SAMPLE_W-1:0]    w_hist_s, w_hist_eff_s;

    assign w_start_s = bus.iValid & bus.iFrameStart;

    fixed_enc_history #(.SAMPLE_W(SAMPLE_W), .MAX_ORDER(MAX_ORDER)) u_history (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .i_valid  (bus.iValid),
        .i_clear  (w_start_s),
        .i_sample (bus.iSample),
        .o_hist   (w_hist_s)
    );

    // A frame-start sample sees the new order, a zero warmup count and no history.
    always_comb begin
        if (w_start_s) begin
            w_ord_s      = clamp_order(bus.iOrder, MAX_ORDER);
            w_cnt_base_s = 3'd0;
            w_hist_eff_s = '0;
        end else begin
            w_ord_s      = r_order;
            w_cnt_base_s = r_warm_cnt;
            w_hist_eff_s = w_hist_s;
        end
        w_warm_s = (w_cnt_base_s < w_ord_s);
    end

    // Latched order and warmup counter (saturates at the order).
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_order    <= 3'd0;
            r_warm_cnt <= 3'd0;
        end else if (bus.iValid) begin
            r_order    <= w_ord_s;
            r_warm_cnt <= w_warm_s ? (w_cnt_base_s + 3'd1) : w_cnt_base_s;
        end
    end

    // Stage 1: captured sample, its history and its predictor decision
    logic                        r_s1_valid, r_s1_fs, r_s1_warm;
    order_t                      r_s1_order;
    logic signed [SAMPLE_W-1:0]  r_s1_x;
    logic [3:0][SAMPLE_W-1:0]    r_s1_hist;

    // Capture stage; bubbles flow through with valid low.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_fs    <= 1'b0;
            r_s1_warm  <= 1'b0;
            r_s1_order <= 3'd0;
            r_s1_x     <= '0;
            r_s1_hist  <= '0;
        end else begin
            r_s1_valid <= bus.iValid;
            if (bus.iValid) begin
                r_s1_fs    <= w_start_s;
                r_s1_warm  <= w_warm_s;
                r_s1_order <= w_ord_s;
                r_s1_x     <= bus.iSample;
                r_s1_hist  <= w_hist_eff_s;
            end
        end
    end

    // Residual: x plus signed coefficients times history; warmup passes x through.
    logic signed [RW-1:0] w_sum_s, w_res_s;
    always_comb begin
        w_sum_s = RW'(r_s1_x);
        for (int k = 1; k <= 4; k++) begin
            w_sum_s = w_sum_s + RW'(fixed_coef(r_s1_order, k)) * RW'($signed(r_s1_hist[k-1]));
        end
        if (r_s1_warm) w_res_s = RW'(r_s1_x);
        else           w_res_s = w_sum_s;
    end

    logic                 r_s2_valid, r_s2_fs, r_s2_warm;
    logic signed [RW-1:0] r_s2_res;
    logic                 r_s3_valid, r_s3_fs, r_s3_warm;
    logic signed [RW-1:0] r_s3_res;
    logic [RW-1:0]        r_s3_abs, w_abs_s;

    // Magnitude for the frame sum; bounded residuals never reach the negative limit.
    always_comb begin
        if (r_s2_res[RW-1]) w_abs_s = RW'(-r_s2_res);
        else                w_abs_s = r_s2_res;
    end

    // Stages 2 and 3: residual and magnitude registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_fs    <= 1'b0;
            r_s2_warm  <= 1'b0;
            r_s2_res   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_fs    <= 1'b0;
            r_s3_warm  <= 1'b0;
            r_s3_res   <= '0;
            r_s3_abs   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_fs    <= r_s1_fs;
            r_s2_warm  <= r_s1_warm;
            r_s2_res   <= w_res_s;
            r_s3_valid <= r_s2_valid;
            r_s3_fs    <= r_s2_fs;
            r_s3_warm  <= r_s2_warm;
            r_s3_res   <= r_s2_res;
            r_s3_abs   <= w_abs_s;
        end
    end

    logic                 r_out_valid, r_out_warm;
    logic signed [RW-1:0] r_out_res;

    // Output registers; residual and flag hold between valid outputs.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_out_valid <= 1'b0;
            r_out_warm  <= 1'b0;
            r_out_res   <= '0;
        end else begin
            r_out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_out_warm <= r_s3_warm;
                r_out_res  <= r_s3_res;
            end
        end
    end

    assign bus.oValid    = r_out_valid;
    assign bus.oWarmup   = r_out_warm;
    assign bus.oResidual = r_out_res;

`ifdef FIXED_ENC_ABSSUM_EN
    localparam int ACC_W1 = ACC_W + 32'sd1;

    logic [ACC_W-1:0] r_acc, w_acc_base_s, w_acc_next_s;
    logic [ACC_W:0]   w_acc_sum_s;

    // Frame-start output restarts the sum; warmup outputs add nothing.
    always_comb begin
        if (r_s3_fs) w_acc_base_s = '0;
        else         w_acc_base_s = r_acc;
        if (r_s3_warm) w_acc_sum_s = {1'b0, w_acc_base_s};
        else           w_acc_sum_s = {1'b0, w_acc_base_s} + ACC_W1'(r_s3_abs);
        if (w_acc_sum_s[ACC_W]) w_acc_next_s = '1;
        else                    w_acc_next_s = w_acc_sum_s[ACC_W-1:0];
    end

    // Running |residual| sum, updated alongside each valid output.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_acc <= '0;
        end else if (r_s3_valid) begin
            r_acc <= w_acc_next_s;
        end
    end

    assign bus.oAbsSum = r_acc;
`endif

endmodule

// File: tb/tb_fixed_encoder_multi_order.sv
module tb_fixed_encoder_multi_order;

    localparam int SW = 16;

    typedef struct {
        longint res;
        bit     warm;
        longint acc;
        int     due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t   q0[$];
    exp_t   q1[$];
    int     m_max [2] = '{4, 3};
    int     m_ord [2];
    int     m_cnt [2];
    longint m_hist[2][4];
    longint m_acc [2];

`ifdef FIXED_ENC_ABSSUM_EN
    fixed_encoder_multi_order_if #(.SAMPLE_W(SW), .ACC_W(32)) bus_a ();
    fixed_encoder_multi_order_if #(.SAMPLE_W(SW), .ACC_W(32)) bus_b ();
`else
    fixed_encoder_multi_order_if #(.SAMPLE_W(SW)) bus_a ();
    fixed_encoder_multi_order_if #(.SAMPLE_W(SW)) bus_b ();
`endif

    fixed_encoder_multi_order #(.SAMPLE_W(SW), .MAX_ORDER(4), .ACC_W(32)) dut_a (
        .iClock(clk), .iReset_n(rst_n), .bus(bus_a));
    fixed_encoder_multi_order #(.SAMPLE_W(SW), .MAX_ORDER(3), .ACC_W(32)) dut_b (
        .iClock(clk), .iReset_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ord[d] = 0;
            m_cnt[d] = 0;
            m_acc[d] = 0;
            for (int j = 0; j < 4; j++) m_hist[d][j] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference FLAC fixed predictor for one design instance.
    task automatic model_step(input int d, input longint x, input bit fs, input int ord_req, input int due);
        longint r, a;
        bit     w;
        exp_t   e;
        if (fs) begin
            m_ord[d] = (ord_req > m_max[d]) ? m_max[d] : ord_req;
            m_cnt[d] = 0;
            for (int j = 0; j < 4; j++) m_hist[d][j] = 0;
        end
        w = (m_cnt[d] < m_ord[d]);
        if (w) m_cnt[d]++;
        case (m_ord[d])
            1: r = x - m_hist[d][0];
            2: r = x - 2*m_hist[d][0] + m_hist[d][1];
            3: r = x - 3*m_hist[d][0] + 3*m_hist[d][1] - m_hist[d][2];
            4: r = x - 4*m_hist[d][0] + 6*m_hist[d][1] - 4*m_hist[d][2] + m_hist[d][3];
            default: r = x;
        endcase
        if (w) r = x;
        if (fs) m_acc[d] = 0;
        if (!w) begin
            a = (r < 0) ? -r : r;
            m_acc[d] = m_acc[d] + a;
            if (m_acc[d] > 64'sd4294967295) m_acc[d] = 64'sd4294967295;
        end
        for (int j = 3; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
        m_hist[d][0] = x;
        e.res = r; e.warm = w; e.acc = m_acc[d]; e.due = due;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input longint x, input bit fs, input int ord);
        logic [SW-1:0] xs;
        logic [2:0]    os;
        @(negedge clk);
        xs = x[SW-1:0];
        os = ord[2:0];
        bus_a.iValid = 1'b1; bus_a.iSample = xs; bus_a.iFrameStart = fs; bus_a.iOrder = os;
        bus_b.iValid = 1'b1; bus_b.iSample = xs; bus_b.iFrameStart = fs; bus_b.iOrder = os;
        model_step(0, x, fs, ord, edge_cnt + 4);
        model_step(1, x, fs, ord, edge_cnt + 4);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_a.iValid = 1'b0; bus_a.iFrameStart = 1'b0;
            bus_b.iValid = 1'b0; bus_b.iFrameStart = 1'b0;
            bus_a.iSample = 16'h5a5a; bus_b.iSample = 16'h5a5a;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while ((q0.size() != 0 || q1.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_a", q0.size(), 0);
        check_eq("drain_b", q1.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on each valid output and checks timing.
    task automatic check_out(input int d);
        logic   v, w;
        longint res, acc;
        int     qs;
        exp_t   e;
        if (d == 0) begin
            v = bus_a.oValid; w = bus_a.oWarmup; res = longint'(bus_a.oResidual); qs = q0.size();
`ifdef FIXED_ENC_ABSSUM_EN
            acc = longint'(bus_a.oAbsSum);
`else
            acc = 0;
`endif
        end else begin
            v = bus_b.oValid; w = bus_b.oWarmup; res = longint'(bus_b.oResidual); qs = q1.size();
`ifdef FIXED_ENC_ABSSUM_EN
            acc = longint'(bus_b.oAbsSum);
`else
            acc = 0;
`endif
        end
        if (v) begin
            if (qs == 0) begin
                check_eq(d == 0 ? "spurious_valid_a" : "spurious_valid_b", 1, 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check_eq(d == 0 ? "resid_a" : "resid_b", res, e.res);
                check_eq(d == 0 ? "warm_a" : "warm_b", longint'(w), longint'(e.warm));
                check_eq(d == 0 ? "latency_a" : "latency_b", edge_cnt, e.due);
`ifdef FIXED_ENC_ABSSUM_EN
                check_eq(d == 0 ? "abssum_a" : "abssum_b", acc, e.acc);
`endif
            end
        end else if (qs != 0) begin
            if (d == 0) e = q0[0];
            else        e = q1[0];
            if (e.due <= edge_cnt) begin
                check_eq(d == 0 ? "missing_out_a" : "missing_out_b", 0, 1);
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_out(0);
            check_out(1);
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid_a"}, longint'(bus_a.oValid), 0);
        check_eq({tag, "_valid_b"}, longint'(bus_b.oValid), 0);
        check_eq({tag, "_res_a"}, longint'(bus_a.oResidual), 0);
        check_eq({tag, "_warm_a"}, longint'(bus_a.oWarmup), 0);
`ifdef FIXED_ENC_ABSSUM_EN
        check_eq({tag, "_abssum_a"}, longint'(bus_a.oAbsSum), 0);
        check_eq({tag, "_abssum_b"}, longint'(bus_b.oAbsSum), 0);
`endif
    endtask

    task automatic run_ord2_seq();
        drive(10, 1'b1, 2);
        drive(20, 1'b0, 2);
        drive(35, 1'b0, 2);
        drive(55, 1'b0, 2);
        drain();
    endtask

    initial begin
        bus_a.iValid = 1'b0; bus_a.iSample = '0; bus_a.iFrameStart = 1'b0; bus_a.iOrder = 3'd0;
        bus_b.iValid = 1'b0; bus_b.iSample = '0; bus_b.iFrameStart = 1'b0; bus_b.iOrder = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Before any frame start: order 0, no warmup.
        drive(3, 1'b0, 4);
        drive(-8, 1'b0, 4);
        drain();

        // Order 2 basic sequence.
        run_ord2_seq();

        // Order 4 full-scale alternation (order 3 on the smaller instance).
        drive(32767, 1'b1, 4);
        drive(-32768, 1'b0, 4);
        drive(32767, 1'b0, 4);
        drive(-32768, 1'b0, 4);
        drive(32767, 1'b0, 4);
        drive(-32768, 1'b0, 4);
        drain();

        // Order 1 with a two-cycle input gap.
        drive(5, 1'b1, 1);
        idle(2);
        drive(9, 1'b0, 1);
        drain();

        // Over-range order request, then a mid-frame order change that must be ignored.
        drive(1, 1'b1, 7);
        drive(4, 1'b0, 7);
        drive(9, 1'b0, 0);
        drive(16, 1'b0, 0);
        drive(25, 1'b0, 0);
        drive(36, 1'b0, 0);
        drain();

        // Back-to-back frames must not share history.
        drive(100, 1'b1, 1);
        drive(50, 1'b0, 1);
        drive(7, 1'b1, 1);
        drive(12, 1'b0, 1);
        drain();

        // Random frames, orders and gaps.
        for (int f = 0; f < 6; f++) begin
            int ord, len;
            ord = $urandom_range(0, 7);
            len = $urandom_range(1, 9);
            for (int s = 0; s < len; s++) begin
                int v;
                v = int'($urandom_range(0, 65535)) - 32768;
                drive(longint'(v), (s == 0), (s == 0) ? ord : int'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        drain();

        // Reset with two samples in flight: nothing may come out for them.
        drive(11, 1'b1, 2);
        drive(22, 1'b0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.iValid = 1'b0; bus_b.iValid = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("inreset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid_a", longint'(bus_a.oValid), 0);
            check_eq("post_rst_valid_b", longint'(bus_b.oValid), 0);
        end
`ifdef FIXED_ENC_ABSSUM_EN
        check_eq("post_rst_abssum_a", longint'(bus_a.oAbsSum), 0);
`endif

        // Same order-2 sequence after reset; frame |residual| sum is 5 + 5.
        run_ord2_seq();
`ifdef FIXED_ENC_ABSSUM_EN
        check_eq("abssum_ord2_a", longint'(bus_a.oAbsSum), 10);
        check_eq("abssum_ord2_b", longint'(bus_b.oAbsSum), 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
